// File: rtl/regfile_sb_if.sv
// regfile_sb_if: read, writeback and reservation bus of regfile_sb.
interface regfile_sb_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic                     busy_any;
  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data, rd_busy, busy_any
  );
  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data, rd_busy, busy_any
  );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with write bypass and pending-write scoreboard.
// Define REGFILE_ZERO_REG_EN to hardwire register 0 to zero (never written, never busy).
module regfile_sb #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int NUM_RD = 2
) (
  input logic          clk,
  input logic          rst,
  regfile_sb_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic              wr_ok, rsv_ok;
  logic [ADDR_W-1:0] ra  [NUM_RD];
  logic              hit [NUM_RD];
  always_comb begin
`ifdef REGFILE_ZERO_REG_EN
    wr_ok  = bus.wr_en && !rst && (bus.wr_addr != '0);
    rsv_ok = bus.rsv_en && !rst && (bus.rsv_addr != '0);
`else
    wr_ok  = bus.wr_en && !rst;
    rsv_ok = bus.rsv_en && !rst;
`endif
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_ok) begin
      regs_d[bus.wr_addr] = bus.wr_data;
      busy_d[bus.wr_addr] = 1'b0;
    end
    // reservation applied last so a new producer wins over a same-cycle write
    if (rsv_ok) busy_d[bus.rsv_addr] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end
  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      ra[p]  = bus.rd_addr[p*ADDR_W +: ADDR_W];
      hit[p] = wr_ok && (bus.wr_addr == ra[p]);
      bus.rd_data[p*DATA_W +: DATA_W] = hit[p] ? bus.wr_data : regs_q[ra[p]];
      bus.rd_busy[p] = !hit[p] && busy_q[ra[p]];
    end
  end
  assign bus.busy_any = |busy_q;
endmodule
